// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves three hazard sources, highest priority first:
//   1. data-memory stall - MEM-stage load/store waiting on dmem_ready
//   2. EX-stage branch   - taken branch/jump flushes IF/ID and ID/EX
//   3. load-use hazard   - ID consumer of an EX load holds for one cycle
// A WAIT-state watchdog aborts a memory access after MEM_TIMEOUT cycles and
// latches a sticky mem_err.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   id_rs1, id_rs2          ID-stage source register indices
//   ex_rd, ex_mem_read      EX-stage destination register and load flag
//   ex_branch_taken         EX-stage redirect
//   mem_req, dmem_ready     MEM-stage access request / memory completion
//   dmem_valid              request to data memory
//   pc_en .. ex_mem_en      pipeline register load enables
//   if_id_flush, id_ex_flush, mem_wb_bubble   NOP insertion controls
//   mem_err                 sticky memory-timeout flag
//   stall_cycles            saturating count of cycles with pc_en=0
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             dmem_valid,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              load_use;
  logic              timeout;
  logic              mem_stall;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Last permitted WAIT cycle without a response: abort instead of stalling.
  assign timeout = (state == WAIT) && !dmem_ready && (wait_cnt == WCNT_LAST);

  // A stall starts in IDLE the first cycle memory is not ready, so a
  // zero-wait access never freezes the pipeline.
  assign mem_stall = (state == IDLE) ? (mem_req && !dmem_ready)
                                     : (!dmem_ready && !timeout);

  always_comb begin
    dmem_valid    = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset) begin
      dmem_valid = (state == IDLE) ? mem_req : !timeout;
      if (mem_stall) begin
        // Whole pipe frozen; the frozen EX branch is resolved on release.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        // The flush discards the load-use consumer, so no stall is needed.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_req && !dmem_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (dmem_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
